// File: rtl/aes_key_expand.sv
// AES key schedule: expands an Nk-word cipher key into 4*(Nr+1) FIPS-197 round-key words, one word per clock.
// aes_pkg provides the S-box, SubWord, RotWord and xtime used by the schedule.
package aes_pkg;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 sits in the top bits of the table, so the offset is 8*(255-x).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

module aes_key_expand
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              rkey_valid,
    output logic [31:0]       rkey [4*(Nr+1)]
);

    localparam int NW = 4 * (Nr + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
        $error("aes_key_expand: Nk must be 4, 6 or 8");
    end

    logic [1:0]  r_state;
    logic [5:0]  r_i;
    logic [2:0]  r_phase;
    logic [7:0]  r_rcon;
    logic        r_valid;
    logic [31:0] r_rkey [NW];

    logic        w_accept;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_next;

    assign key_ready  = (r_state != S_EXPAND);
    assign busy       = (r_state == S_EXPAND);
    assign rkey_valid = r_valid;
    assign rkey       = r_rkey;
    assign w_accept   = key_valid && key_ready;

    // Both operands of the recurrence come straight from the round-key array.
    assign w_prev = r_rkey[r_i - 6'd1];
    assign w_back = r_rkey[r_i - 6'(Nk)];
    assign w_sub  = sub_word((r_phase == 3'd0) ? rot_word(w_prev) : w_prev);

    // NOTE: every path assigns w_temp a default first, so no latch is inferred.
    always_comb begin
        w_temp = w_prev;
        if (r_phase == 3'd0)
            w_temp = w_sub ^ {r_rcon, 24'h0};
        else if (Nk == 8 && r_phase == 3'd4)
            w_temp = w_sub;
    end

    assign w_next = w_back ^ w_temp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
            // NOTE: the round-key array is a visible output that must read zero after reset, so it is built from resettable flops rather than RAM.
            for (int j = 0; j < NW; j++)
                r_rkey[j] <= '0;
        end else if (w_accept) begin
            for (int j = 0; j < Nk; j++)
                r_rkey[j] <= key[32*(Nk-j)-1 -: 32];
            r_i     <= 6'(Nk);
            r_phase <= '0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
            r_state <= S_EXPAND;
        end else if (r_state == S_EXPAND) begin
            r_rkey[r_i] <= w_next;
            r_i         <= r_i + 6'd1;
            r_phase     <= (r_phase == 3'(Nk - 1)) ? 3'd0 : r_phase + 3'd1;
            if (r_phase == 3'd0)
                r_rcon <= xtime(r_rcon);
            if (r_i == 6'(NW - 1)) begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: three instances (Nk=4/6/8) checked every cycle against an algebraic
// key-schedule model, plus FIPS-197 literals and an end-to-end inverse-cipher decryption.
module tb_aes_key_expand;

    localparam logic [127:0] KEY4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] KEYC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   kv, kr, by, rv;
    logic [127:0] k4;
    logic [191:0] k6;
    logic [255:0] k8;
    logic [31:0]  rk4 [44];
    logic [31:0]  rk6 [52];
    logic [31:0]  rk8 [60];

    always #5 clk = ~clk;

    aes_key_expand #(.Nk(4)) u4 (.clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]),
        .key(k4), .busy(by[0]), .rkey_valid(rv[0]), .rkey(rk4));
    aes_key_expand #(.Nk(6)) u6 (.clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]),
        .key(k6), .busy(by[1]), .rkey_valid(rv[1]), .rkey(rk6));
    aes_key_expand #(.Nk(8)) u8 (.clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]),
        .key(k8), .busy(by[2]), .rkey_valid(rv[2]), .rkey(rk8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_sbox  [256];
    logic [7:0]  m_isbox [256];
    logic [31:0] m_w     [3][60];
    int          m_left  [3];
    bit          m_valid [3];
    bit          m_zero  [3];
    bit          m_live = 1'b0;
    int          nks [3] = '{4, 6, 8};
    int          nws [3] = '{44, 52, 60};
    logic [31:0] e_w [44];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    task automatic model_expand(input int d, input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int j = 0; j < nk; j++)
            m_w[d][j] = k[255-32*j -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = m_w[d][i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            m_w[d][i] = m_w[d][i-nk] ^ t;
        end
    endtask

    function automatic logic [255:0] key_of(input int d);
        case (d)
            0:       return {k4, 128'h0};
            1:       return {k6, 64'h0};
            default: return k8;
        endcase
    endfunction

    function automatic logic [31:0] dut_word(input int d, input int i);
        case (d)
            0:       return (i < 44) ? rk4[i] : 32'h0;
            1:       return (i < 52) ? rk6[i] : 32'h0;
            default: return (i < 60) ? rk8[i] : 32'h0;
        endcase
    endfunction

    function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] out;
        for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8];
        for (int r = 10; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    s[4*c+b] = s[4*c+b] ^ e_w[4*r+c][31-8*b -: 8];
            if (r == 0) break;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    t[4*c+b] = s[4*((c - b + 4) % 4) + b];
            for (int j = 0; j < 16; j++) s[j] = m_isbox[t[j]];
        end
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
        return out;
    endfunction

    // Model: an accept starts Nw-Nk edges of busy, after which the expected schedule is valid.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_left[d]  = 0;
                m_valid[d] = 1'b0;
                m_zero[d]  = 1'b1;
            end else if (kv[d] && m_left[d] == 0) begin
                m_left[d]  = nws[d] - nks[d];
                m_valid[d] = 1'b0;
                m_zero[d]  = 1'b0;
                model_expand(d, nks[d], key_of(d));
            end else if (m_left[d] > 0) begin
                m_left[d]--;
                if (m_left[d] == 0) m_valid[d] = 1'b1;
            end
        end
    end

    // Compare: control outputs every cycle; the whole array whenever its contents are defined.
    always @(negedge clk) begin
        if (m_live) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("busy%0d", d), 32'(by[d]), 32'(m_left[d] > 0));
                check($sformatf("key_ready%0d", d), 32'(kr[d]), 32'(m_left[d] == 0));
                check($sformatf("rkey_valid%0d", d), 32'(rv[d]), 32'(m_valid[d]));
                if (m_valid[d] || m_zero[d]) begin
                    int idx = 0;
                    for (int i = 0; i < nws[d]; i++) begin
                        if (dut_word(d, i) !== (m_zero[d] ? 32'h0 : m_w[d][i])) begin
                            idx = i;
                            break;
                        end
                    end
                    check($sformatf("rkey%0d[%0d]", d, idx), dut_word(d, idx),
                          m_zero[d] ? 32'h0 : m_w[d][idx]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input int d, output int lat);
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (rv[d]) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat [3];
        int l;
        int nz;
        logic [127:0] pt;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            m_sbox[a]  = s;
            m_isbox[s] = 8'(a);
        end
        check("model_sbox00", 32'(m_sbox[8'h00]), 32'h63);
        check("model_sbox53", 32'(m_sbox[8'h53]), 32'hed);
        check("model_isbox16", 32'(m_isbox[8'h16]), 32'hff);

        rst = 1'b1; kv = '0; k4 = '0; k6 = '0; k8 = '0;
        repeat (2) @(posedge clk);
        #1 m_live = 1'b1;
        @(negedge clk) rst = 1'b0;

        // FIPS-197 vectors on all three key sizes at once; key is scrambled after accept.
        @(negedge clk);
        k4 = KEY4; k6 = KEY6; k8 = KEY8; kv = 3'b111;
        @(posedge clk);
        #1;
        kv = '0;
        k4 = {$urandom, $urandom, $urandom, $urandom};
        k6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        lat = '{-1, -1, -1};
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if (rv[d] && lat[d] < 0) lat[d] = e;
        end
        check("latency_nk4", 32'(lat[0]), 32'd40);
        check("latency_nk6", 32'(lat[1]), 32'd46);
        check("latency_nk8", 32'(lat[2]), 32'd52);
        check("nk4_w4", rk4[4], 32'ha0fafe17);
        check("nk4_w40", rk4[40], 32'hd014f9a8);
        check("nk4_w41", rk4[41], 32'hc9ee2589);
        check("nk4_w42", rk4[42], 32'he13f0cc8);
        check("nk4_w43", rk4[43], 32'hb6630ca6);
        check("nk6_w51", rk6[51], 32'h01002202);
        check("nk8_w56", rk8[56], 32'hfe4890d1);
        check("nk8_w57", rk8[57], 32'he6188d0b);
        check("nk8_w58", rk8[58], 32'h046df344);
        check("nk8_w59", rk8[59], 32'h706c631e);
        check("model_nk4_w4", m_w[0][4], 32'ha0fafe17);
        check("model_nk6_w51", m_w[1][51], 32'h01002202);
        check("model_nk8_w59", m_w[2][59], 32'h706c631e);

        // End-to-end: the DUT round keys must decrypt the FIPS-197 ciphertext.
        for (int i = 0; i < 44; i++) e_w[i] = rk4[i];
        pt = inv_cipher(CT);
        for (int j = 0; j < 4; j++)
            check($sformatf("e2e_pt%0d", j), pt[127-32*j -: 32], PT[127-32*j -: 32]);

        // Reset wins over a simultaneous accept.
        @(negedge clk);
        rst = 1'b1; kv[0] = 1'b1; k4 = KEY4;
        @(posedge clk);
        #1;
        check("rst_vs_accept_valid", 32'(rv[0]), 32'd0);
        check("rst_vs_accept_busy", 32'(by[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0; kv = '0;

        // Reset ten edges into an expansion, then a fresh key.
        @(negedge clk);
        kv[0] = 1'b1; k4 = KEY4;
        @(posedge clk);
        #1 kv[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        nz = 0;
        for (int i = 0; i < 44; i++) if (rk4[i] !== 32'h0) nz++;
        check("midop_rst_nonzero_words", 32'(nz), 32'd0);
        check("midop_rst_valid", 32'(rv[0]), 32'd0);
        check("midop_rst_ready", 32'(kr[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        kv[0] = 1'b1; k4 = KEYC1;
        @(posedge clk);
        #1 kv[0] = 1'b0;
        wait_valid(0, l);
        check("after_rst_latency", 32'(l), 32'd40);
        check("keyc1_w40", rk4[40], 32'h13111d7f);

        // key_valid held during EXPAND is ignored.
        @(negedge clk);
        kv[0] = 1'b1; k4 = KEY4;
        @(posedge clk);
        #1;
        k4 = KEYC1;
        repeat (20) begin
            @(posedge clk);
            #1 check("ready_while_busy", 32'(kr[0]), 32'd0);
        end
        @(negedge clk) kv[0] = 1'b0;
        wait_valid(0, l);
        check("ignore_latency", 32'(l), 32'd20);
        check("ignore_w43", rk4[43], 32'hb6630ca6);

        // Re-key from DONE: rkey_valid drops at the accept edge.
        @(negedge clk);
        kv[0] = 1'b1; k4 = KEYC1;
        @(posedge clk);
        #1;
        kv[0] = 1'b0;
        check("rekey_valid_drop", 32'(rv[0]), 32'd0);
        check("rekey_busy", 32'(by[0]), 32'd1);
        wait_valid(0, l);
        check("rekey_latency", 32'(l), 32'd40);

        // Back-to-back: accept on the first edge after rkey_valid rises.
        kv[0] = 1'b1; k4 = KEY4;
        @(posedge clk);
        #1;
        kv[0] = 1'b0;
        check("b2b_accept_busy", 32'(by[0]), 32'd1);
        wait_valid(0, l);
        check("b2b_latency", 32'(l), 32'd40);
        check("b2b_w40", rk4[40], 32'hd014f9a8);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
